decode_sequencer: RTL and testbench
===================================

# decode_sequencer

Sequencing front end for the decode stage: accepts fetched instructions over a valid/ready handshake, buffers them in a 2-entry skid queue, and decodes opcode, register fields and the sign-extended immediate. It presents one registered decode bundle per cycle to execute and inserts a single bubble on load-use hazards. It sits between fetch and execute, and drops all in-flight work on a redirect flush.

## Interface
- INST_SIZE, 32, instruction width
- DATA_SIZE, 32, immediate / PC width
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  fetch presents an instruction
- o_ready  out  1  queue can accept (registered, = entry count < 2)
- i_instr  in  INST_SIZE  fetched instruction
- i_pc  in  DATA_SIZE  PC of i_instr
- i_flush  in  1  redirect; discard everything in flight
- o_valid  out  1  decode bundle valid
- i_ex_ready  in  1  execute consumes bundle this cycle
- o_opcode  out  t_opcode  decoded opcode enum
- o_rd, o_rs1, o_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- o_funct3  out  3  instr[14:12]
- o_funct7  out  7  instr[31:25]
- o_immediate  out  DATA_SIZE  signed, sign-extended immediate
- o_pc  out  DATA_SIZE  PC of bundle
- o_illegal  out  1  opcode not in supported set
- o_bubble_cnt  out  32  saturating count of inserted hazard bubbles

## Operation
- Queue: 2-entry FIFO. Push on i_valid && o_ready; pop when the head is loaded into the output register.
- Output register loads the head when (!o_valid || i_ex_ready) && queue non-empty && no hazard. Otherwise, if i_ex_ready, o_valid drops to 0.
- Opcode map on instr[6:0]: 0000011 LOADS, 0100011 STORES, 0010011 ALC_I, 0110011 ALC_R, 1100011 BRANCHES, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR. Any other value sets o_illegal=1, o_immediate=0, and still issues.
- Immediate, sign-extended from bit 31:
  - LOADS / ALC_I / JALR: instr[31:20]
  - STORES: {instr[31:25], instr[11:7]}
  - BRANCHES: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - LUI / AUIPC: {instr[31:12], 12'h0}
  - JAL: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - ALC_R: 0
- rs1 is used by LOADS, STORES, ALC_I, ALC_R, BRANCHES, JALR. rs2 is used by STORES, ALC_R, BRANCHES.
- Load-use hazard: the output holds a valid LOADS with rd != 0 and is consumed this cycle, and the queue head uses rs1 or rs2 equal to that rd.
  - Next cycle: o_valid=0 (one bubble), head stays queued, o_bubble_cnt += 1 (saturates at 2^32-1).
  - The following cycle, the head issues normally.
  - Bubble state is a 1-bit FSM: ISSUE -> BUBBLE on hazard, BUBBLE -> ISSUE unconditionally.
- Flush has priority over every other event. At the next edge: queue empty, o_valid=0, FSM=ISSUE. A push presented in the flush cycle is dropped. o_bubble_cnt is not cleared.

## Timing
- Reset (async assert, sync-safe release):
  - o_valid=0, o_ready=1, o_bubble_cnt=0
  - o_opcode=LOADS, all other bundle fields 0, o_illegal=0
  - queue empty, FSM=ISSUE
- Latency: an instruction accepted at edge N, with empty queue and free output, is valid after edge N+1.
- Throughput: 1 instruction/cycle with no hazards and i_ex_ready held high.
- o_ready is registered. It deasserts the cycle after the queue reaches 2 entries and reasserts the cycle after a pop leaves 1 entry; no push is ever lost.
- Simultaneous push and pop with the queue full: the pop frees an entry, but o_ready was 0, so no push occurs.
- Stall: while o_valid && !i_ex_ready, all bundle outputs hold stable.
- Flush while in BUBBLE: the bubble is cancelled and the FSM returns to ISSUE.
- Reset mid-stream: all state clears immediately on i_rst_n low.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) -> o_valid one cycle later; o_opcode=ALC_I, o_rd=1, o_immediate=5, o_illegal=0.
- Push lw x2,0(x1) then add x3,x2,x2 with i_ex_ready=1 -> exactly one o_valid=0 cycle between them; o_bubble_cnt=1. Repeat with add x3,x1,x1 -> no bubble.
- Immediate formats: sw with imm -4 (0xFE112E23) -> 0xFFFFFFFC; beq imm -8 -> 0xFFFFFFF8; jal imm 2048 -> 0x00000800; lui 0xABCDE -> 0xABCDE000.
- Hold i_ex_ready=0 while pushing 3 instructions -> o_ready low after the 2nd queued instruction; bundle stable; after release, all 3 issue in order with no loss.
- Fill the queue, assert i_flush for one cycle together with i_valid -> next cycle o_valid=0 and queue empty; the flushed-cycle instruction never appears.
- Push opcode 0x7F -> o_illegal=1, o_immediate=0. Assert i_rst_n low mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/decode_sequencer.sv
// Decode-stage sequencer: 2-entry skid queue, field/immediate decode,
// registered bundle to execute with a single load-use bubble.
package decode_sequencer_pkg;
  typedef enum logic [3:0] {
    LOADS, STORES, ALC_I, ALC_R, BRANCHES,
    LUI, AUIPC, JAL, JALR, ILLEGAL
  } t_opcode;
endpackage

module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int INST_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INST_SIZE-1:0] i_instr,
  input  logic [DATA_SIZE-1:0] i_pc,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ex_ready,
  output t_opcode              o_opcode,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [2:0]           o_funct3,
  output logic [6:0]           o_funct7,
  output logic [DATA_SIZE-1:0] o_immediate,
  output logic [DATA_SIZE-1:0] o_pc,
  output logic                 o_illegal,
  output logic [31:0]          o_bubble_cnt
);

  typedef enum logic {ISSUE, BUBBLE} t_state;

  t_state               state;
  logic [INST_SIZE-1:0] q_instr [2];
  logic [DATA_SIZE-1:0] q_pc [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_nxt;
  logic [INST_SIZE-1:0] h;
  t_opcode              dec_op;
  logic [DATA_SIZE-1:0] dec_imm;
  logic                 use1;
  logic                 use2;
  logic                 head_hit;
  logic                 hazard;
  logic                 load;
  logic                 push;

  assign h = q_instr[rd_ptr];

  always_comb begin
    dec_op  = ILLEGAL;
    dec_imm = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    case (h[6:0])
      7'b0000011: begin
        dec_op  = LOADS;
        dec_imm = DATA_SIZE'($signed(h[31:20]));
        use1    = 1'b1;
      end
      7'b0100011: begin
        dec_op  = STORES;
        dec_imm = DATA_SIZE'($signed({h[31:25], h[11:7]}));
        use1    = 1'b1;
        use2    = 1'b1;
      end
      7'b0010011: begin
        dec_op  = ALC_I;
        dec_imm = DATA_SIZE'($signed(h[31:20]));
        use1    = 1'b1;
      end
      7'b0110011: begin
        dec_op = ALC_R;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      7'b1100011: begin
        dec_op  = BRANCHES;
        dec_imm = DATA_SIZE'($signed({h[31], h[7],
                    h[30:25], h[11:8], 1'b0}));
        use1    = 1'b1;
        use2    = 1'b1;
      end
      7'b0110111: begin
        dec_op  = LUI;
        dec_imm = DATA_SIZE'($signed({h[31:12], 12'h0}));
      end
      7'b0010111: begin
        dec_op  = AUIPC;
        dec_imm = DATA_SIZE'($signed({h[31:12], 12'h0}));
      end
      7'b1101111: begin
        dec_op  = JAL;
        dec_imm = DATA_SIZE'($signed({h[31], h[19:12],
                    h[20], h[30:21], 1'b0}));
      end
      7'b1100111: begin
        dec_op  = JALR;
        dec_imm = DATA_SIZE'($signed(h[31:20]));
        use1    = 1'b1;
      end
      default: ;
    endcase
  end

  // Only a load being consumed right now can starve the queue head
  assign head_hit = (count != 2'd0) &&
    ((use1 && h[19:15] == o_rd) ||
     (use2 && h[24:20] == o_rd));
  assign hazard = (state == ISSUE) && o_valid &&
    (o_opcode == LOADS) && (o_rd != 5'd0) &&
    i_ex_ready && head_hit;
  assign load = (!o_valid || i_ex_ready) &&
    (count != 2'd0) && !hazard;
  assign push = i_valid && o_ready && !i_flush;
  assign count_nxt = count + 2'(push) - 2'(load);

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_instr[wr_ptr] <= i_instr;
      q_pc[wr_ptr]    <= i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      o_ready <= 1'b1;
    end else if (i_flush) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (load) rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      o_ready <= (count_nxt < 2'd2);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ISSUE;
      o_valid      <= 1'b0;
      o_opcode     <= LOADS;
      o_rd         <= '0;
      o_rs1        <= '0;
      o_rs2        <= '0;
      o_funct3     <= '0;
      o_funct7     <= '0;
      o_immediate  <= '0;
      o_pc         <= '0;
      o_illegal    <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_flush) begin
      state   <= ISSUE;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE:   state <= hazard ? BUBBLE : ISSUE;
        BUBBLE:  state <= ISSUE;
        default: state <= ISSUE;
      endcase
      if (hazard && o_bubble_cnt != '1)
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      if (load) begin
        o_valid     <= 1'b1;
        o_opcode    <= dec_op;
        o_rd        <= h[11:7];
        o_rs1       <= h[19:15];
        o_rs2       <= h[24:20];
        o_funct3    <= h[14:12];
        o_funct7    <= h[31:25];
        o_immediate <= dec_imm;
        o_pc        <= q_pc[rd_ptr];
        o_illegal   <= (dec_op == ILLEGAL);
      end else if (i_ex_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: directed test-plan steps plus random
// traffic, each cycle compared to a queue-based reference model.
module tb_decode_sequencer;
  import decode_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        ovalid;
  logic        ex_ready;
  t_opcode     opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] opc;
  logic        illegal;
  logic [31:0] bcnt;

  int checks = 0;
  int errors = 0;

  decode_sequencer #(.INST_SIZE(32), .DATA_SIZE(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .o_ready(ready), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .o_valid(ovalid),
    .i_ex_ready(ex_ready), .o_opcode(opcode), .o_rd(rd),
    .o_rs1(rs1), .o_rs2(rs2), .o_funct3(funct3),
    .o_funct7(funct7), .o_immediate(imm), .o_pc(opc),
    .o_illegal(illegal), .o_bubble_cnt(bcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    t_opcode     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } bund_t;

  bund_t       pend [$];
  bund_t       mout;
  bit          mvalid;
  bit          mready;
  bit          mbubble;
  logic [31:0] mcnt;
  logic [31:0] pc_ctr = 32'h1000;
  logic [6:0]  ops [10] = '{7'h03, 7'h23, 7'h13, 7'h33,
    7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

  function automatic bund_t expect_decode(
    input logic [31:0] i, input logic [31:0] p);
    bund_t b;
    logic [31:0] itype;
    itype = $signed(i) >>> 20;
    b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
    b.f3 = i[14:12]; b.f7 = i[31:25]; b.pc = p;
    b.ill = 1'b0; b.imm = 32'h0;
    case (i[6:0])
      7'h03: begin b.op = LOADS; b.imm = itype; end
      7'h23: begin b.op = STORES; b.imm = {itype[31:5], i[11:7]}; end
      7'h13: begin b.op = ALC_I; b.imm = itype; end
      7'h33: b.op = ALC_R;
      7'h63: begin
        b.op = BRANCHES;
        b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37: begin b.op = LUI; b.imm = i & 32'hFFFFF000; end
      7'h17: begin b.op = AUIPC; b.imm = i & 32'hFFFFF000; end
      7'h6F: begin
        b.op = JAL;
        b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin b.op = JALR; b.imm = itype; end
      default: begin b.op = ILLEGAL; b.ill = 1'b1; end
    endcase
    return b;
  endfunction

  function automatic bit reads_reg(input bund_t b, input logic [4:0] r);
    bit u1, u2;
    u1 = b.op inside {LOADS, STORES, ALC_I, ALC_R, BRANCHES, JALR};
    u2 = b.op inside {STORES, ALC_R, BRANCHES};
    return (u1 && b.rs1 == r) || (u2 && b.rs2 == r);
  endfunction

  task automatic model_reset();
    pend.delete();
    mvalid = 0; mready = 1; mbubble = 0; mcnt = 32'h0;
    mout.op = LOADS; mout.rd = 0; mout.rs1 = 0; mout.rs2 = 0;
    mout.f3 = 0; mout.f7 = 0; mout.imm = 0; mout.pc = 0;
    mout.ill = 0;
  endtask

  task automatic model_edge();
    bit psh, hz, ld;
    psh = valid && mready;
    if (flush) begin
      pend.delete();
      mvalid = 0; mbubble = 0; mready = 1;
      return;
    end
    hz = !mbubble && mvalid && mout.op == LOADS && mout.rd != 0 &&
         ex_ready && pend.size() > 0 && reads_reg(pend[0], mout.rd);
    ld = (!mvalid || ex_ready) && pend.size() > 0 && !hz;
    mbubble = hz;
    if (hz && mcnt != 32'hFFFFFFFF) mcnt = mcnt + 1;
    if (ld) begin
      mout = pend.pop_front();
      mvalid = 1;
    end else if (ex_ready) begin
      mvalid = 0;
    end
    if (psh) pend.push_back(expect_decode(instr, pc));
    mready = pend.size() < 2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", 32'(ovalid), 32'(mvalid));
    chk("o_ready", 32'(ready), 32'(mready));
    chk("o_bubble_cnt", bcnt, mcnt);
    chk("o_opcode", 32'(opcode), 32'(mout.op));
    chk("o_rd", 32'(rd), 32'(mout.rd));
    chk("o_rs1", 32'(rs1), 32'(mout.rs1));
    chk("o_rs2", 32'(rs2), 32'(mout.rs2));
    chk("o_funct3", 32'(funct3), 32'(mout.f3));
    chk("o_funct7", 32'(funct7), 32'(mout.f7));
    chk("o_immediate", imm, mout.imm);
    chk("o_pc", opc, mout.pc);
    chk("o_illegal", 32'(illegal), 32'(mout.ill));
  endtask

  task automatic step(input bit v, input logic [31:0] ins,
                      input bit fl, input bit exr);
    bit acc;
    @(negedge clk);
    valid = v; instr = ins; pc = pc_ctr;
    flush = fl; ex_ready = exr;
    acc = v && mready && !fl;
    @(posedge clk);
    model_edge();
    if (acc) pc_ctr = pc_ctr + 4;
    #1 check_all();
  endtask

  task automatic issue_one(input logic [31:0] ins);
    step(1, ins, 0, 1);
    step(0, 32'h0, 0, 1);
    chk("issue_valid", 32'(ovalid), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 0; valid = 0; instr = 0; pc = 0;
    flush = 0; ex_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1;

    // addi x1,x0,5: valid one edge after acceptance
    step(1, 32'h00500093, 0, 1);
    chk("addi_not_yet", 32'(ovalid), 32'd0);
    step(0, 32'h0, 0, 1);
    chk("addi_valid", 32'(ovalid), 32'd1);
    chk("addi_op", 32'(opcode), 32'(ALC_I));
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_ill", 32'(illegal), 32'd0);

    // lw x2,0(x1) ; add x3,x2,x2 -> one bubble
    step(1, 32'h0000A103, 0, 1);
    step(1, 32'h002101B3, 0, 1);
    chk("lw_valid", 32'(ovalid), 32'd1);
    step(0, 32'h0, 0, 1);
    chk("bubble_gap", 32'(ovalid), 32'd0);
    chk("bubble_cnt", bcnt, 32'd1);
    step(0, 32'h0, 0, 1);
    chk("add_after_bubble", 32'(ovalid), 32'd1);
    chk("add_rd", 32'(rd), 32'd3);

    // lw x2 ; add x3,x1,x1 -> no bubble
    step(1, 32'h0000A103, 0, 1);
    step(1, 32'h001081B3, 0, 1);
    step(0, 32'h0, 0, 1);
    chk("nohaz_valid", 32'(ovalid), 32'd1);
    chk("nohaz_rs1", 32'(rs1), 32'd1);
    chk("nohaz_cnt", bcnt, 32'd1);

    issue_one(32'hFE112E23);
    chk("sw_imm", imm, 32'hFFFFFFFC);
    issue_one(32'hFE000CE3);
    chk("beq_imm", imm, 32'hFFFFFFF8);
    issue_one(32'h0010006F);
    chk("jal_imm", imm, 32'h00000800);
    issue_one(32'hABCDE037);
    chk("lui_imm", imm, 32'hABCDE000);
    issue_one(32'hFFF0007F);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_imm", imm, 32'h0);
    step(0, 32'h0, 0, 1);

    // stall: 3 pushes with execute blocked
    step(1, 32'h00100293, 0, 0);
    step(1, 32'h00100313, 0, 0);
    step(1, 32'h00100393, 0, 0);
    chk("full_ready", 32'(ready), 32'd0);
    step(1, 32'h00100413, 0, 0);
    step(0, 32'h0, 0, 0);
    chk("stall_rd", 32'(rd), 32'd5);
    step(0, 32'h0, 0, 1);
    chk("drain_b", 32'(rd), 32'd6);
    chk("drain_ready", 32'(ready), 32'd1);
    step(0, 32'h0, 0, 1);
    chk("drain_c", 32'(rd), 32'd7);
    step(0, 32'h0, 0, 1);
    chk("drain_empty", 32'(ovalid), 32'd0);

    // flush with full queue, then with room for the push
    step(1, 32'h00100293, 0, 0);
    step(1, 32'h00100313, 0, 0);
    step(1, 32'h00100393, 0, 0);
    step(1, 32'h00900493, 1, 0);
    chk("flush_valid", 32'(ovalid), 32'd0);
    chk("flush_ready", 32'(ready), 32'd1);
    step(1, 32'h00100293, 0, 0);
    step(1, 32'h00900493, 1, 0);
    repeat (3) begin
      step(0, 32'h0, 0, 1);
      chk("flush_dropped", 32'(ovalid), 32'd0);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      r[24:20] = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[11:7]  = 5'($urandom_range(0, 3));
      r[6:0]   = ops[$urandom_range(0, 9)];
      step(($urandom % 4) != 0, r, ($urandom % 40) == 0,
           ($urandom % 4) != 0);
    end

    // reset mid-stream
    step(1, 32'h0000A103, 0, 0);
    step(1, 32'h002101B3, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("midrst_cnt", bcnt, 32'd0);
    @(negedge clk);
    rst_n = 1; valid = 0; flush = 0;
    step(0, 32'h0, 0, 1);
    issue_one(32'h00500093);
    chk("post_rst_imm", imm, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
